// File: rtl/cic3_pkg.sv
// Shared definitions for the CIC3 filter-row readout block.
// Holds row defaults, the output channel-index width and the output FSM states.
// No logic of its own; imported by every file of the block.
package cic3_pkg;

    localparam int NUM_CHANNELS_DEF = 24;
    localparam int WORD_WIDTH_DEF   = 16;
    localparam int CHAN_IDX_W       = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } rd_state_t;

endpackage

// File: rtl/cic3_ser2par.sv
// Parallel serial-to-parallel converter for a row of MSB-first filter outputs, sharing one bit counter.
// Latency: the full word is presented combinationally during the LSB cycle, together with word_done_o.
// No backpressure: the serial stream cannot be stalled; the consumer must take the word in the LSB cycle.
module cic3_ser2par #(
    parameter int NUM_CH = 24,
    parameter int WORD_W = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CH-1:0]              filt_out_i,
    input  logic                           frame_start_i,
    output logic [NUM_CH-1:0][WORD_W-1:0]  word_o,
    output logic                           word_done_o,
    output logic                           sync_err_o
);

    localparam int             CW       = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(WORD_W - 1);

    logic                          active_q, active_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [NUM_CH-1:0][WORD_W-1:0] sr_q, sr_d;

    // Counter sequencing and per-channel shifting; frame_start always restarts at the MSB.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        if (frame_start_i) begin
            // A restart drops whatever partial word was in flight.
            active_d = 1'b1;
            cnt_d    = CW'(1);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                sr_d[ch] = {{(WORD_W-1){1'b0}}, filt_out_i[ch]};
            end
        end else if (active_q) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                sr_d[ch] = {sr_q[ch][WORD_W-2:0], filt_out_i[ch]};
            end
            if (cnt_q == LAST_BIT) begin
                active_d = 1'b0;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // In the LSB cycle the next-state shift value is the complete word, LSB included.
    assign word_o      = sr_d;
    assign word_done_o = active_q && (cnt_q == LAST_BIT) && !frame_start_i;
    assign sync_err_o  = frame_start_i && active_q;

    // Counter and shift-register state.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            sr_q     <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
        end
    end

endmodule

// File: rtl/cic3_row_readout.sv
// Deserializes a row of CIC3 filter outputs and streams the enabled words out one channel at a time.
// Latency: first out_valid one clk after the LSB cycle (frame_start at t -> out_valid at t+WORD_WIDTH).
// Backpressure: out_valid/out_ready; a frame completing while the bank is still draining is dropped (overflow).
module cic3_row_readout
    import cic3_pkg::*;
#(
    parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
    parameter int WORD_WIDTH   = WORD_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] filt_out,
    input  logic                    frame_start,
    input  logic [NUM_CHANNELS-1:0] chan_en,
    input  logic                    clear_status,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_WIDTH-1:0]   out_data,
    output logic [CHAN_IDX_W-1:0]   out_chan,
    output logic                    out_last,
    output logic                    overflow,
    output logic                    sync_err
);

    logic [NUM_CHANNELS-1:0][WORD_WIDTH-1:0] cap_words;
    logic                                    word_done;
    logic                                    sync_evt;

    cic3_ser2par #(
        .NUM_CH (NUM_CHANNELS),
        .WORD_W (WORD_WIDTH)
    ) u_ser2par (
        .clk           (clk),
        .reset         (reset),
        .filt_out_i    (filt_out),
        .frame_start_i (frame_start),
        .word_o        (cap_words),
        .word_done_o   (word_done),
        .sync_err_o    (sync_evt)
    );

    rd_state_t                               state_q, state_d;
    logic [NUM_CHANNELS-1:0][WORD_WIDTH-1:0] bank_q, bank_d;
    logic [NUM_CHANNELS-1:0]                 mask_q, mask_d;
    logic [CHAN_IDX_W-1:0]                   cur_q, cur_d;
    logic                                    overflow_q, overflow_d;
    logic                                    sync_err_q, sync_err_d;

    logic [CHAN_IDX_W-1:0] cap_first;
    logic [CHAN_IDX_W-1:0] nxt_idx;
    logic                  has_next;
    logic                  hs;
    logic                  freeing;
    logic                  bank_busy;
    logic                  capture;
    logic                  ovf_evt;

    // Lowest enabled channel of the incoming mask, and next enabled channel above the current one.
    always_comb begin
        cap_first = '0;
        nxt_idx   = '0;
        has_next  = 1'b0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (chan_en[i]) begin
                cap_first = CHAN_IDX_W'(i);
            end
            if (mask_q[i] && (i > int'(cur_q))) begin
                nxt_idx  = CHAN_IDX_W'(i);
                has_next = 1'b1;
            end
        end
    end

    // The bank counts as free in the cycle its final word is accepted, so a coincident capture is taken.
    assign hs        = (state_q == ST_SEND) && out_ready;
    assign freeing   = hs && !has_next;
    assign bank_busy = (state_q == ST_SEND) && !freeing;
    assign capture   = word_done && (|chan_en) && !bank_busy;
    assign ovf_evt   = word_done && bank_busy;

    // Output FSM next state: load bank on capture, step through enabled channels on each handshake.
    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        mask_d  = mask_q;
        cur_d   = cur_q;
        if (capture) begin
            state_d = ST_SEND;
            bank_d  = cap_words;
            mask_d  = chan_en;
            cur_d   = cap_first;
        end else if (freeing) begin
            state_d = ST_IDLE;
            mask_d  = '0;
            cur_d   = '0;
        end else if (hs) begin
            cur_d = nxt_idx;
        end
    end

    // Sticky flags: a set event in the same cycle as clear_status keeps the flag set.
    always_comb begin
        overflow_d = overflow_q;
        sync_err_d = sync_err_q;
        if (clear_status) begin
            overflow_d = 1'b0;
            sync_err_d = 1'b0;
        end
        if (ovf_evt) begin
            overflow_d = 1'b1;
        end
        if (sync_evt) begin
            sync_err_d = 1'b1;
        end
    end

    // State, bank and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bank_q     <= '0;
            mask_q     <= '0;
            cur_q      <= '0;
            overflow_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            mask_q     <= mask_d;
            cur_q      <= cur_d;
            overflow_q <= overflow_d;
            sync_err_q <= sync_err_d;
        end
    end

    // Output drive; word fields are forced to zero whenever nothing is offered.
    always_comb begin
        out_valid = (state_q == ST_SEND);
        out_data  = '0;
        out_chan  = '0;
        out_last  = 1'b0;
        if (state_q == ST_SEND) begin
            out_data = bank_q[cur_q];
            out_chan = cur_q;
            out_last = !has_next;
        end
    end

    assign overflow = overflow_q;
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_cic3_row_readout.sv
// Scoreboard bench for cic3_row_readout: directed frames, expected words queued as each frame is issued.
// A negedge monitor pops and compares on every handshake and checks zeroing and stall stability.
// Ready is driven either as a level or as a per-cycle toggle.
module tb_cic3_row_readout;

    localparam int NCH = 24;
    localparam int WW  = 16;

    typedef logic [NCH-1:0][WW-1:0] frame_t;
    typedef struct packed {
        logic [4:0]    chan;
        logic [WW-1:0] data;
        logic          last;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NCH-1:0] filt_out = '0;
    logic           frame_start = 1'b0;
    logic [NCH-1:0] chan_en = '0;
    logic           clear_status = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [WW-1:0]  out_data;
    logic [4:0]     out_chan;
    logic           out_last;
    logic           overflow;
    logic           sync_err;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   vld_cnt = 0;
    logic mon_en = 1'b0;
    logic ready_lvl = 1'b0;
    logic ready_toggle = 1'b0;

    cic3_row_readout #(.NUM_CHANNELS(NCH), .WORD_WIDTH(WW)) dut (
        .clk          (clk),
        .reset        (reset),
        .filt_out     (filt_out),
        .frame_start  (frame_start),
        .chan_en      (chan_en),
        .clear_status (clear_status),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_chan     (out_chan),
        .out_last     (out_last),
        .overflow     (overflow),
        .sync_err     (sync_err)
    );

    always #5 clk = ~clk;

    // Ready driver settles at #2 so the stimulus (at #1) can change ready_lvl in the same cycle.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (ready_toggle) out_ready = ~out_ready;
            else              out_ready = ready_lvl;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: scoreboard pops, zero-when-idle and stall stability.
    logic          stall_q = 1'b0;
    logic [21:0]   held_q = '0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) vld_cnt++;
            if (!out_valid) begin
                checks++;
                if ({out_data, out_chan, out_last} !== '0) begin
                    failures++;
                    $display("FAIL idle_zero: got data=%0h chan=%0d last=%0b want all 0", out_data, out_chan, out_last);
                end
            end
            if (stall_q && out_valid) begin
                checks++;
                if ({out_data, out_chan, out_last} !== held_q) begin
                    failures++;
                    $display("FAIL stall_stable: got %0h want %0h", {out_data, out_chan, out_last}, held_q);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word: got chan=%0d data=%0h want no word", out_chan, out_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (out_chan !== e.chan || out_data !== e.data || out_last !== e.last) begin
                        failures++;
                        $display("FAIL word: got chan=%0d data=%0h last=%0b want chan=%0d data=%0h last=%0b",
                                 out_chan, out_data, out_last, e.chan, e.data, e.last);
                    end
                end
            end
            stall_q <= out_valid && !out_ready;
            held_q  <= {out_data, out_chan, out_last};
        end
    end

    function automatic frame_t mk_frame(input logic [15:0] seed);
        frame_t w;
        for (int i = 0; i < NCH; i++) w[i] = seed + 16'(i) * 16'h0111;
        return w;
    endfunction

    function automatic void push_frame(input frame_t w, input logic [NCH-1:0] en, input int max_words);
        int hi = 0;
        int n = 0;
        for (int i = 0; i < NCH; i++) if (en[i]) hi = i;
        for (int i = 0; i < NCH; i++) begin
            if (en[i] && n < max_words) begin
                sb.push_back('{chan: 5'(i), data: w[i], last: (i == hi)});
                n++;
            end
        end
    endfunction

    // Drives nbits serial bits MSB-first starting with frame_start; call at #1 after an edge.
    task automatic drive_frame(input frame_t w, input logic [NCH-1:0] en, input int nbits, input logic clr);
        for (int b = 0; b < nbits; b++) begin
            frame_start  = (b == 0);
            clear_status = clr && (b == 0);
            chan_en      = en;
            for (int ch = 0; ch < NCH; ch++) filt_out[ch] = w[ch][WW-1-b];
            @(posedge clk);
            #1;
        end
        frame_start  = 1'b0;
        clear_status = 1'b0;
        filt_out     = NCH'($urandom);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string nm, input int max);
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(nm, (n >= max), 0);
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        cycles(1);
        clear_status = 1'b0;
    endtask

    initial begin
        frame_t w;
        int     snap;

        // Reset state
        cycles(3);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_chan", out_chan, 0);
        chk("rst_last", out_last, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_sync_err", sync_err, 0);
        reset  = 1'b0;
        mon_en = 1'b1;
        cycles(2);

        // Basic frame, all channels, ready held high
        ready_lvl = 1'b1;
        w = mk_frame(16'h0000);
        for (int i = 0; i < NCH; i++) w[i] = 16'h0101 * 16'(i);
        w[0]  = 16'hA5C3;
        w[23] = 16'h1234;
        push_frame(w, 24'hFFFFFF, NCH);
        snap = vld_cnt;
        drive_frame(w, 24'hFFFFFF, WW, 1'b0);
        chk("basic_no_early_valid", vld_cnt - snap, 0);
        chk("basic_first_valid_t16", out_valid, 1);
        chk("basic_first_chan", out_chan, 0);
        chk("basic_first_data", out_data, 16'hA5C3);
        cycles(24);
        chk("basic_back_to_back_done", sb.size(), 0);
        chk("basic_idle_after", out_valid, 0);
        cycles(3);

        // Mask 0x000005 with ready toggling
        ready_toggle = 1'b1;
        w = mk_frame(16'h3C00);
        push_frame(w, 24'h000005, NCH);
        drive_frame(w, 24'h000005, WW, 1'b0);
        wait_drain("mask_drain_timeout", 40);
        ready_toggle = 1'b0;
        cycles(3);

        // Overflow: two frames with ready low, second dropped
        ready_lvl = 1'b0;
        cycles(2);
        w = mk_frame(16'h5000);
        push_frame(w, 24'h800001, NCH);
        drive_frame(w, 24'h800001, WW, 1'b0);
        chk("ovf_before_second", overflow, 0);
        drive_frame(mk_frame(16'h9000), 24'hFFFFFF, WW, 1'b0);
        chk("ovf_set", overflow, 1);
        chk("ovf_bank_kept_chan", out_chan, 0);
        chk("ovf_bank_kept_data", out_data, 16'h5000);
        ready_lvl = 1'b1;
        wait_drain("ovf_drain_timeout", 20);
        cycles(20);
        chk("ovf_second_absent", sb.size(), 0);
        pulse_clear();
        chk("ovf_cleared", overflow, 0);

        // Back-to-back: 16-channel frame whose last handshake coincides with the next LSB
        w = mk_frame(16'h2200);
        push_frame(w, 24'h00FFFF, NCH);
        push_frame(mk_frame(16'h7700), 24'hFFFFFF, NCH);
        drive_frame(w, 24'h00FFFF, WW, 1'b0);
        drive_frame(mk_frame(16'h7700), 24'hFFFFFF, WW, 1'b0);
        chk("b2b_second_starts_chan", out_chan, 0);
        chk("b2b_second_starts_data", out_data, 16'h7700);
        wait_drain("b2b_drain_timeout", 40);
        chk("b2b_no_overflow", overflow, 0);

        // Sync error: restart at bit 7, clear in the same cycle loses to the set
        chk("sync_clean_before", sync_err, 0);
        drive_frame(mk_frame(16'hE000), 24'hFFFFFF, 7, 1'b0);
        w = mk_frame(16'h4400);
        push_frame(w, 24'h000F00, NCH);
        drive_frame(w, 24'h000F00, WW, 1'b1);
        chk("sync_err_set", sync_err, 1);
        wait_drain("sync_drain_timeout", 30);
        pulse_clear();
        chk("sync_err_cleared", sync_err, 0);

        // Reset after 5 handshakes
        w = mk_frame(16'h6100);
        push_frame(w, 24'hFFFFFF, 5);
        drive_frame(w, 24'hFFFFFF, WW, 1'b0);
        cycles(5);
        ready_lvl = 1'b0;
        reset     = 1'b1;
        cycles(1);
        chk("rst_mid_valid", out_valid, 0);
        reset     = 1'b0;
        ready_lvl = 1'b1;
        chk("rst_mid_words_seen", sb.size(), 0);
        chk("rst_mid_overflow", overflow, 0);
        chk("rst_mid_sync_err", sync_err, 0);
        cycles(30);
        chk("rst_mid_quiet", out_valid, 0);
        w = mk_frame(16'h0A0A);
        push_frame(w, 24'h000003, NCH);
        drive_frame(w, 24'h000003, WW, 1'b0);
        wait_drain("rst_new_frame_timeout", 20);
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cic3_row_readout.md
CIC3_ROW_READOUT -- requirements
Module: cic3_row_readout

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 24, meaning the number of serial filter outputs in the row.
REQ-002 SHALL have parameter WORD_WIDTH, default 16, meaning the bits per filter output word, sent MSB-first.
REQ-003 SHALL have port clk, input, 1 bit: the high-speed modulator clock, shared with the filter row; one clock; all logic on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port filt_out, input, NUM_CHANNELS bits: the serial output bit of each filter, one bit per clk.
REQ-006 SHALL have port frame_start, input, 1 bit: a one-cycle pulse marking the cycle in which the MSB is present on all channels.
REQ-007 SHALL have port chan_en, input, NUM_CHANNELS bits: the channel enable mask, sampled at frame capture.
REQ-008 SHALL have port clear_status, input, 1 bit: a pulse that clears the sticky flags.
REQ-009 SHALL have port out_valid, output, 1 bit: the output word is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the word.
REQ-011 SHALL have port out_data, output, WORD_WIDTH bits: the deserialized filter word.
REQ-012 SHALL have port out_chan, output, 5 bits: the channel index of out_data, 0..NUM_CHANNELS-1.
REQ-013 SHALL have port out_last, output, 1 bit: marks the last enabled channel of a frame.
REQ-014 SHALL have ports overflow and sync_err, outputs, 1 bit each: the sticky status flags.

Function
REQ-015 SHALL deserialize all channels in parallel with a shared bit counter running 0..WORD_WIDTH-1; frame_start loads bit 0 (MSB).
REQ-016 SHALL capture all NUM_CHANNELS words plus chan_en into a holding bank on the clk edge ending the LSB cycle (frame_start at cycle t gives the LSB at t+WORD_WIDTH-1).
REQ-017 SHALL keep the counter idle until the next frame_start once a word completes; filt_out is ignored while idle.
REQ-018 SHALL restart the counter at MSB, discard the partial words and set sync_err when frame_start arrives with the counter in 1..WORD_WIDTH-1.
REQ-019 SHALL use output FSM states IDLE and SEND; IDLE->SEND on bank capture with a non-zero sampled mask; an all-zero mask captures nothing and stays IDLE.
REQ-020 SHALL, in SEND, hold out_valid=1 and hold out_data/out_chan stable until out_valid&out_ready; channels are sent in ascending index order, skipping disabled ones.
REQ-021 SHALL assert the first out_valid in cycle t+WORD_WIDTH, i.e. one cycle after the LSB.
REQ-022 SHALL assert out_last with the highest enabled channel; its handshake frees the bank and returns the FSM to IDLE.
REQ-023 SHALL drop a frame completing while the bank is occupied (old bank kept intact) and set overflow.
REQ-024 SHALL accept a capture that coincides with the final handshake (out_last&out_ready) without overflow; the FSM stays in SEND on the new bank with the lowest enabled channel.
REQ-025 SHALL clear both sticky flags on clear_status; a set event in the same cycle wins.
REQ-026 SHALL drive out_data, out_chan and out_last to 0 whenever out_valid=0.

Reset
REQ-027 SHALL, on reset, set the bit counter idle, the bank empty, FSM=IDLE, out_valid=0, out_data=0, out_chan=0, out_last=0, overflow=0 and sync_err=0.
REQ-028 SHALL abandon any in-progress word and any undrained bank on reset mid-operation, without setting any flag.

Structure
REQ-029 SHALL place the FSM state enum, NUM_CHANNELS and WORD_WIDTH defaults, and the channel-index width in shared package cic3_pkg.
REQ-030 SHALL use one sub-module, cic3_ser2par, holding per-channel shift registers with the shared counter, instantiated once with width NUM_CHANNELS.

Verification
REQ-031 SHALL cover basic frame: frame_start, ch0 serial 0xA5C3, ch23 0x1234, all enabled, out_ready=1 -> 24 words ch0..23 back-to-back, first at t+16, ch0=0xA5C3, out_last only on ch23=0x1234.
REQ-032 SHALL cover mask plus backpressure: chan_en=0x000005, out_ready toggling 1/0 -> exactly ch0 then ch2, data stable while stalled, out_last on ch2.
REQ-033 SHALL cover overflow: out_ready=0 and two consecutive frames -> overflow=1, the first frame's data is output after ready rises, and the second frame never appears.
REQ-034 SHALL cover back-to-back: the second frame's LSB lands in the same cycle as the first frame's out_last handshake -> overflow=0 and the second frame is output in full.
REQ-035 SHALL cover sync error: frame_start at bit 7, then a clean frame -> sync_err=1 and only the clean frame's words are output; clear_status then gives sync_err=0.
REQ-036 SHALL cover reset mid-SEND: reset after 5 handshakes -> out_valid=0 the next cycle and nothing further is output until a new complete frame.
